// File: rtl/vpu_tile_addr_gen.sv
// Three-channel tile address generator for the VPU matmul datapath (A, W, C operands).
// Each channel turns a start index pair into an edge-truncated burst of up to TILE addresses.

module vpu_tile_addr_gen_chan #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DIM_WIDTH  = 8,
    parameter int                    TILE       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  row,
    input  logic [DIM_WIDTH-1:0]  col,
    input  logic [DIM_WIDTH-1:0]  stride,
    input  logic [DIM_WIDTH-1:0]  limit,
    input  logic                  walk_col,
    input  logic                  ready,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            state_dbg
);
    localparam int CW = $clog2(TILE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           remain;
    logic [CW-1:0]           len;
    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   first_addr;
    logic [DIM_WIDTH-1:0]    walk_start;
    logic [31:0]             span;
    logic                    accept;
    logic                    last;

    // Burst length: distance to the matrix edge along the walk, capped at TILE.
    always_comb begin
        walk_start = walk_col ? col : row;
        span       = 32'(limit) - 32'(walk_start);
        len        = '0;
        if (walk_start < limit) begin
            len = (span >= 32'(TILE)) ? CW'(TILE) : CW'(span);
        end
    end

    always_comb begin
        first_addr = BASE + ADDR_WIDTH'(row) * ADDR_WIDTH'(stride) + ADDR_WIDTH'(col);
    end

    assign accept = (state == BURST) && ready;
    assign last   = (remain == CW'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start outside IDLE (including FIN) is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? FIN : BURST;
                end
            end
            BURST: begin
                if (accept && last) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        valid     = (state == BURST);
        busy      = (state != IDLE);
        done      = (state == FIN);
        state_dbg = state;
    end

    // The row/col step is latched so address updates are a single add per beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr   <= '0;
            step   <= '0;
            remain <= '0;
        end else if (state == IDLE) begin
            if (start && (len != '0)) begin
                addr   <= first_addr;
                step   <= walk_col ? ADDR_WIDTH'(1) : ADDR_WIDTH'(stride);
                remain <= len;
            end
        end else if (accept) begin
            remain <= remain - CW'(1);
            if (!last) begin
                addr <= addr + step;
            end
        end
    end
endmodule

module vpu_tile_addr_gen #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DIM_WIDTH  = 8,
    parameter int                    TILE       = 4,
    parameter logic [ADDR_WIDTH-1:0] A_BASE     = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] W_BASE     = 16'h0100,
    parameter logic [ADDR_WIDTH-1:0] C_BASE     = 16'h0200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic                  a_start,
    input  logic [DIM_WIDTH-1:0]  a_row,
    input  logic [DIM_WIDTH-1:0]  a_col,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_busy,
    output logic                  a_done,
    input  logic                  w_start,
    input  logic [DIM_WIDTH-1:0]  w_row,
    input  logic [DIM_WIDTH-1:0]  w_col,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_busy,
    output logic                  w_done,
    input  logic                  c_start,
    input  logic                  c_mode,
    input  logic [DIM_WIDTH-1:0]  c_row,
    input  logic [DIM_WIDTH-1:0]  c_col,
    output logic                  c_valid,
    input  logic                  c_ready,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic                  c_busy,
    output logic                  c_done,
    output logic [1:0]            a_state,
    output logic [1:0]            w_state,
    output logic [1:0]            c_state
);
    // Handshake on every channel: a beat transfers on a rising edge where valid && ready;
    // valid only rises from a start and addr holds steady while valid && !ready.

    logic [DIM_WIDTH-1:0] c_limit;

    assign c_limit = c_mode ? cfg_n : cfg_m;

    // A walks along its row (k increments), bounded by cfg_k.
    vpu_tile_addr_gen_chan #(
        .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .TILE(TILE), .BASE(A_BASE)
    ) u_a (
        .clk(clk), .reset(reset), .start(a_start),
        .row(a_row), .col(a_col), .stride(cfg_k), .limit(cfg_k), .walk_col(1'b1),
        .ready(a_ready), .valid(a_valid), .busy(a_busy), .done(a_done),
        .addr(a_addr), .state_dbg(a_state)
    );

    // W walks down a column (k increments), bounded by cfg_k.
    vpu_tile_addr_gen_chan #(
        .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .TILE(TILE), .BASE(W_BASE)
    ) u_w (
        .clk(clk), .reset(reset), .start(w_start),
        .row(w_row), .col(w_col), .stride(cfg_n), .limit(cfg_k), .walk_col(1'b0),
        .ready(w_ready), .valid(w_valid), .busy(w_busy), .done(w_done),
        .addr(w_addr), .state_dbg(w_state)
    );

    vpu_tile_addr_gen_chan #(
        .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH), .TILE(TILE), .BASE(C_BASE)
    ) u_c (
        .clk(clk), .reset(reset), .start(c_start),
        .row(c_row), .col(c_col), .stride(cfg_n), .limit(c_limit), .walk_col(c_mode),
        .ready(c_ready), .valid(c_valid), .busy(c_busy), .done(c_done),
        .addr(c_addr), .state_dbg(c_state)
    );
endmodule
